// File: rtl/mem_responder.sv
// mem_responder: responder side of the core's load/store memory interface.
// Serves one request at a time from a byte-lane RAM or an MMIO window holding
// a free-running cycle timer (MMIO_BASE+0) and a scratch register (MMIO_BASE+4).
// A programmable number of wait states precede the access cycle.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req               request strobe, sampled only while idle
//   op[2:0]           op[2]: 1 store / 0 load; op[1:0]: 00 byte, 01 half, 10 word
//   addr[31:0]        byte address
//   write_data[31:0]  right-aligned store data
//   busy              transaction in flight (through the resp_valid cycle)
//   resp_valid        one-cycle completion pulse
//   read_data[31:0]   zero-extended load result, held until the next response
//   fault             error flag, held with read_data
module mem_responder #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        fault
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   acc_data_q, acc_data_d;
  logic          acc_fault_q, acc_fault_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          fault_q, fault_d;
  logic          resp_valid_q, resp_valid_d;
  logic          busy_q, busy_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   scratch_q, scratch_d;

  logic [3:0][7:0] ram_q [RAM_WORDS];

  logic [1:0]      size_c;
  logic            is_store_c;
  logic            in_ram_c, is_tmr_c, is_scr_c, misalign_c, fault_c;
  logic [AW-1:0]   widx_c;
  logic [3:0][7:0] word_rd_c;
  logic [31:0]     load_c;
  logic [3:0]      be_c;
  logic [3:0][7:0] wlanes_c;
  logic            ram_we_c;

  // Address decode, fault detection and lane steering for the latched request.
  // Every fault class yields the same response, so the priority order only
  // matters conceptually; the conditions are simply OR-ed.
  always_comb begin
    size_c     = op_q[1:0];
    is_store_c = op_q[2];
    in_ram_c   = 33'(addr_q) < RAM_BYTES;
    is_tmr_c   = (addr_q == MMIO_BASE);
    is_scr_c   = (addr_q == MMIO_BASE + 32'd4);
    misalign_c = ((size_c == 2'b01) && addr_q[0]) ||
                 ((size_c == 2'b10) && (addr_q[1:0] != 2'b00));
    fault_c    = (size_c == 2'b11) || misalign_c ||
                 !(in_ram_c || is_tmr_c || is_scr_c) ||
                 ((is_tmr_c || is_scr_c) && (size_c != 2'b10)) ||
                 (is_tmr_c && is_store_c);

    widx_c    = addr_q[AW+1:2];
    word_rd_c = ram_q[widx_c];
    case (size_c)
      2'b00:   load_c = 32'(word_rd_c[addr_q[1:0]]);
      2'b01:   load_c = addr_q[1] ? {16'h0, word_rd_c[3], word_rd_c[2]}
                                  : {16'h0, word_rd_c[1], word_rd_c[0]};
      default: load_c = word_rd_c;
    endcase

    case (size_c)
      2'b00: begin
        be_c     = 4'b0001 << addr_q[1:0];
        wlanes_c = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be_c     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes_c = {2{wd_q[15:0]}};
      end
      default: begin
        be_c     = 4'b1111;
        wlanes_c = wd_q;
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    acc_data_d   = acc_data_q;
    acc_fault_d  = acc_fault_q;
    read_data_d  = read_data_q;
    fault_d      = fault_q;
    resp_valid_d = 1'b0;
    scratch_d    = scratch_q;
    timer_d      = timer_q + 32'd1;
    ram_we_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d   = op;
          addr_d = addr;
          wd_d   = write_data;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        acc_fault_d = fault_c;
        acc_data_d  = '0;
        if (!fault_c) begin
          if (!is_store_c) begin
            if (is_tmr_c)      acc_data_d = timer_q;
            else if (is_scr_c) acc_data_d = scratch_q;
            else               acc_data_d = load_c;
          end else if (is_scr_c) begin
            scratch_d = wd_q;
          end else begin
            ram_we_c = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        read_data_d  = acc_data_q;
        fault_d      = acc_fault_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // busy also covers the cycle in which resp_valid is high.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
      acc_data_q   <= '0;
      acc_fault_q  <= 1'b0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      timer_q      <= '0;
      scratch_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      acc_data_q   <= acc_data_d;
      acc_fault_q  <= acc_fault_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
    end
  end

  // RAM contents survive reset; writes are gated so an aborted request never lands.
  always_ff @(posedge clk) begin
    if (ram_we_c && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) ram_q[widx_c][i] <= wlanes_c[i];
      end
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign read_data  = read_data_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=2 instance (dut) and a WAIT_STATES=0
// instance (dut0) share clock, reset and request payload; each has its own req.
module tb_mem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;
  localparam logic [31:0] SCR  = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req0 = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, rv, flt, busy0, rv0, flt0;
  logic [31:0] rd, rd0;

  mem_responder dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
    .write_data(wdata), .busy(busy), .resp_valid(rv), .read_data(rd), .fault(flt)
  );

  mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .op(op), .addr(addr),
    .write_data(wdata), .busy(busy0), .resp_valid(rv0), .read_data(rd0), .fault(flt0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
  } exp_t;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ef;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference cycle timer; t_off tracks a forced jump of the DUT timer.
  logic [31:0] m_cnt = '0;
  logic [31:0] t_off = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt <= '0;
    else       m_cnt <= m_cnt + 32'd1;
  end

  int rv_cnt = 0;
  always @(negedge clk) if (rv) rv_cnt++;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic wait_resp(input bit sel, input string nm, output int k);
    bit   got;
    exp_t e;
    got = 1'b0;
    k   = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = sel ? rv0 : rv;
    end
    e = sb.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no resp_valid after %0d cycles, expected data %08h", nm, k, e.d);
    end else begin
      check32({nm, "_data"}, sel ? rd0 : rd, e.d);
      check32({nm, "_fault"}, 32'(sel ? flt0 : flt), 32'(e.f));
    end
  endtask

  task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ef,
                       input bit tmr, input string nm);
    int k;
    int ws;
    ws = sel ? 0 : 2;
    @(negedge clk);
    op    = o;
    addr  = a;
    wdata = wd;
    if (tmr) ed = m_cnt + t_off + 32'(ws) + 32'd1;
    sb.push_back('{ed, ef});
    if (sel) req0 = 1'b1;
    else     req  = 1'b1;
    @(posedge clk);
    #1;
    req  = 1'b0;
    req0 = 1'b0;
    wait_resp(sel, nm, k);
    check32({nm, "_lat"}, 32'(k), 32'(ws + 3));
    @(negedge clk);
    check32({nm, "_pulse"}, 32'(sel ? rv0 : rv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [25];

  initial begin
    int          k;
    int          rv_before;
    logic [31:0] t0, r1, r2;

    vecs[0]  = '{"st_w_10",    3'b110, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{"ld_w_10",    3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"st_w_10b",   3'b110, 32'h10,   32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{"st_b_13",    3'b100, 32'h13,   32'hFFFFFFA5, 32'h0,        1'b0};
    vecs[4]  = '{"ld_w_10c",   3'b010, 32'h10,   32'h0,        32'hA5223344, 1'b0};
    vecs[5]  = '{"ld_h_12",    3'b001, 32'h12,   32'h0,        32'h0000A522, 1'b0};
    vecs[6]  = '{"ld_b_11",    3'b000, 32'h11,   32'h0,        32'h00000033, 1'b0};
    vecs[7]  = '{"st_scr",     3'b110, SCR,      32'hCAFEF00D, 32'h0,        1'b0};
    vecs[8]  = '{"f_ld_h_21",  3'b001, 32'h21,   32'h0,        32'h0,        1'b1};
    vecs[9]  = '{"f_ld_w_22",  3'b010, 32'h22,   32'h0,        32'h0,        1'b1};
    vecs[10] = '{"f_size3",    3'b011, 32'h10,   32'h0,        32'h0,        1'b1};
    vecs[11] = '{"f_ld_oob",   3'b010, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{"f_ld_b_tmr", 3'b000, MMIO,     32'h0,        32'h0,        1'b1};
    vecs[13] = '{"f_st_tmr",   3'b110, MMIO,     32'h1,        32'h0,        1'b1};
    vecs[14] = '{"f_st_h_11",  3'b101, 32'h11,   32'hFFFF,     32'h0,        1'b1};
    vecs[15] = '{"f_st_oob",   3'b110, 32'h1000, 32'h5A5A5A5A, 32'h0,        1'b1};
    vecs[16] = '{"f_st_b_scr", 3'b100, SCR,      32'h0,        32'h0,        1'b1};
    vecs[17] = '{"ld_scr",     3'b010, SCR,      32'h0,        32'hCAFEF00D, 1'b0};
    vecs[18] = '{"ld_w_10d",   3'b010, 32'h10,   32'h0,        32'hA5223344, 1'b0};
    vecs[19] = '{"st_w_20",    3'b110, 32'h20,   32'h0,        32'h0,        1'b0};
    vecs[20] = '{"st_h_22",    3'b101, 32'h22,   32'h1234BEEF, 32'h0,        1'b0};
    vecs[21] = '{"ld_w_20",    3'b010, 32'h20,   32'h0,        32'hBEEF0000, 1'b0};
    vecs[22] = '{"f_st_size3", 3'b111, SCR,      32'h0,        32'h0,        1'b1};
    vecs[23] = '{"ld_scr2",    3'b010, SCR,      32'h0,        32'hCAFEF00D, 1'b0};
    vecs[24] = '{"f_ld_mmio8", 3'b010, MMIO + 32'd8, 32'h0,    32'h0,        1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_rv", 32'(rv), 32'd0);
    check32("rst_rd", rd, 32'd0);
    check32("rst_fault", 32'(flt), 32'd0);
    reset = 1'b0;

    foreach (vecs[i])
      issue(1'b0, vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].ed, vecs[i].ef, 1'b0, vecs[i].nm);

    // Zero-wait-state instance
    issue(1'b1, 3'b110, SCR,   32'h12345678, 32'h0,        1'b0, 1'b0, "ws0_st_scr");
    issue(1'b1, 3'b010, SCR,   32'h0,        32'h12345678, 1'b0, 1'b0, "ws0_ld_scr");
    issue(1'b1, 3'b110, 32'h8, 32'h01020304, 32'h0,        1'b0, 1'b0, "ws0_st_w");
    issue(1'b1, 3'b000, 32'hA, 32'h0,        32'h00000002, 1'b0, 1'b0, "ws0_ld_b");
    issue(1'b1, 3'b010, MMIO,  32'h0,        32'h0,        1'b0, 1'b1, "ws0_tmr");

    // Timer: two loads with req held high, accepted five cycles apart
    @(negedge clk);
    op   = 3'b010;
    addr = MMIO;
    t0   = m_cnt + t_off;
    sb.push_back('{t0 + 32'd3, 1'b0});
    sb.push_back('{t0 + 32'd8, 1'b0});
    req = 1'b1;
    wait_resp(1'b0, "tmr_b2b_1", k);
    r1 = rd;
    @(negedge clk);
    req = 1'b0;
    wait_resp(1'b0, "tmr_b2b_2", k);
    r2 = rd;
    check32("tmr_spacing", r2 - r1, 32'd5);

    // Reset in the middle of a store's wait states
    issue(1'b0, 3'b110, 32'h40, 32'h77, 32'h0,  1'b0, 1'b0, "st_w_40");
    issue(1'b0, 3'b010, 32'h40, 32'h0,  32'h77, 1'b0, 1'b0, "ld_w_40");
    @(negedge clk);
    op    = 3'b110;
    addr  = 32'h40;
    wdata = 32'h55;
    req   = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check32("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check32("abort_busy", 32'(busy), 32'd0);
    check32("abort_rv", 32'(rv), 32'd0);
    check32("abort_rd", rd, 32'd0);
    check32("abort_fault", 32'(flt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    t_off = '0;
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h77, 1'b0, 1'b0, "ld_w_40_after_abort");
    issue(1'b0, 3'b010, SCR,    32'h0, 32'h0,  1'b0, 1'b0, "ld_scr_after_rst");
    issue(1'b0, 3'b010, MMIO,   32'h0, 32'h0,  1'b0, 1'b1, "tmr_after_rst");

    // req pulses while busy must not start extra transactions
    rv_before = rv_cnt;
    @(negedge clk);
    op   = 3'b010;
    addr = 32'h10;
    req  = 1'b1;
    sb.push_back('{32'hA5223344, 1'b0});
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check32("busy_pulses_rv_count", 32'(rv_cnt - rv_before), 32'd1);
    check32("busy_pulses_idle", 32'(busy), 32'd0);
    begin
      exp_t e;
      e = sb.pop_front();
      check32("busy_pulses_data", rd, e.d);
    end

    // Timer wrap
    @(negedge clk);
    force dut.timer_q = 32'hFFFF_FFFE;
    t_off = 32'hFFFF_FFFE - m_cnt;
    #1;
    release dut.timer_q;
    issue(1'b0, 3'b010, MMIO, 32'h0, 32'h0, 1'b0, 1'b1, "tmr_wrap1");
    issue(1'b0, 3'b010, MMIO, 32'h0, 32'h0, 1'b0, 1'b1, "tmr_wrap2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder side of the core's data/instruction memory interface.
- Accepts one load/store request at a time through a request/response handshake.
- Serves requests from an internal byte-lane RAM plus a small MMIO register window (free-running cycle timer, scratch register).
- Inserts a programmable number of wait states, so the core FSM can be exercised against a slow memory.

Parameters:
- RAM_WORDS, 1024, RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
- WAIT_STATES, 2, extra cycles between request acceptance and the access cycle (0 allowed).
- MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- op  input  3  op[2]=1 store / 0 load; op[1:0] size: 00 byte, 01 half, 10 word, 11 illegal.
- addr  input  32  byte address.
- write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  output  1  high from the cycle after acceptance until resp_valid is deasserted.
- resp_valid  output  1  one-cycle pulse marking completion.
- read_data  output  32  load result, zero-extended and right-aligned; held until the next resp_valid.
- fault  output  1  valid with resp_valid; held with read_data.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, resp_valid=0, read_data=0, fault=0, timer=0, scratch=0. RAM contents are not reset. An in-flight request is aborted with no RAM or scratch write.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE & req: latch op, addr and write_data. Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: a counter loaded with WAIT_STATES-1 decrements each cycle; go to ACCESS when it reaches 0.
  - ACCESS: decode, check faults, perform the read or write, register read_data and fault; go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; return to IDLE.
- Latency: req sampled at edge N gives resp_valid high during the cycle after edge N+WAIT_STATES+2.
- busy=1 in WAIT, ACCESS and RESP. req while not IDLE is ignored and not queued. req held high in IDLE starts a new transaction the cycle after RESP.
- Fault conditions (checked in ACCESS, in this priority):
  1. size 11.
  2. Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  3. Address neither in RAM nor equal to MMIO_BASE+0 / MMIO_BASE+4.
  4. Non-word access to MMIO.
  5. Store to the timer (MMIO_BASE+0).
- On fault: no RAM or register update, read_data=0, fault=1.
- RAM store: update only the addressed lanes.
  - Byte lane = addr[1:0], data from write_data[7:0].
  - Half lanes = addr[1]*2 .. +1, data from write_data[15:0].
- RAM load: extract the addressed lanes and shift to bit 0. Stores return read_data=0, fault=0.
- Timer: 32-bit counter, +1 every cycle including reset release; wraps FFFF_FFFF->0. A load returns its value registered in the ACCESS cycle.
- Scratch (MMIO_BASE+4): word read/write.
- A store followed by a load to the same address returns the stored data; no bypass hazard exists because accesses are serialized.

Test Plan:
1. WAIT_STATES=2: word store 32'hDEADBEEF to 0x10, then word load 0x10 -> read_data=DEADBEEF, fault=0; resp_valid exactly 4 cycles after each req edge, one cycle wide.
2. Byte store 8'hA5 to 0x13 over word 0x11223344 at 0x10 -> word load 0x10 =A5223344; half load 0x12 =0000A522; byte load 0x11 =00000033.
3. Faults: half load 0x21; word load 0x22; op=3'b011; load 4*RAM_WORDS; byte load MMIO_BASE; store MMIO_BASE -> each fault=1, read_data=0, RAM and scratch unchanged.
4. Timer: two word loads of MMIO_BASE issued back to back -> difference = request spacing; force timer to FFFF_FFFE -> reads show wrap to 0.
5. Assert reset during WAIT of a word store 0x0000_0055 to 0x40 -> outputs 0 immediately, state IDLE, later load 0x40 returns the prior value; req pulses while busy produce no extra resp_valid.
6. WAIT_STATES=0: scratch store 0x12345678 then load -> 0x12345678, resp_valid 2 cycles after the req edge.
